// File: rtl/r4add_seq.sv
// r4add_seq: sequencer for the radix-4 MSDF online adder (r4add).
//
// Collects one NDIG-digit operand pair MSD-first from a valid/ready stream into
// a local buffer. It then drives the adder for NDIG+DELTA back-to-back cycles,
// because the adder has no enable. The last DELTA of those cycles carry zero
// flush digits. The module emits the NDIG result digits with valid/last
// framing and owns the adder's reset (add_clr).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             begin an operation (sampled only in IDLE)
//   busy, done        state != IDLE; one-cycle completion pulse
//   in_valid/in_ready operand digit handshake (in_ready high only in LOAD)
//   x_in, y_in        signed radix-4 operand digits (-3..+3, 3'b100 illegal)
//   out_valid/last    result digit framing; s_out is the result digit
//   err_digit         sticky illegal-digit flag, cleared by the next start
//   add_clr           registered reset for the attached r4add
//   add_x, add_y      digits fed to r4add
//   add_s             r4add sum digit
module r4add_seq #(
  parameter int NDIG  = 8,
  parameter int DELTA = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] x_in,
  input  logic [2:0] y_in,
  output logic       out_valid,
  output logic       out_last,
  output logic [2:0] s_out,
  output logic       err_digit,
  output logic       add_clr,
  output logic [2:0] add_x,
  output logic [2:0] add_y,
  input  logic [2:0] add_s
);

  localparam int CW = $clog2(NDIG + DELTA + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] LOAD_LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(NDIG + DELTA - 1);
  localparam logic [CW-1:0] NDIG_C    = CW'(NDIG);
  localparam logic [CW-1:0] DELTA_C   = CW'(DELTA);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          accept;

  // Each entry holds {x, y}; illegal digits are already replaced by zero.
  logic [5:0]    dig_buf [NDIG];

  assign idx    = cnt[IW-1:0];
  assign accept = (state == LOAD) && in_valid;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state receives a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: if (accept && cnt == LOAD_LAST) next_state = RUN;
      RUN:  if (cnt == RUN_LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    in_ready  = (state == LOAD);
    out_valid = 1'b0;
    out_last  = 1'b0;
    s_out     = 3'd0;
    add_x     = 3'd0;
    add_y     = 3'd0;
    if (state == RUN) begin
      // The adder runs gaplessly. Past the operand length it receives zero
      // digits to flush the online delay.
      if (cnt < NDIG_C) begin
        add_x = dig_buf[idx][5:3];
        add_y = dig_buf[idx][2:0];
      end
      // The first DELTA adder outputs precede the first valid sum digit.
      out_valid = (cnt >= DELTA_C);
      out_last  = (cnt == RUN_LAST);
      if (out_valid) s_out = add_s;
    end
  end

  // Counter, error flag and adder clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      err_digit <= 1'b0;
      add_clr   <= 1'b1;
    end else begin
      // Clearing is released only for RUN, so each RUN starts from the
      // adder's reset state.
      add_clr <= (next_state != RUN);
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            err_digit <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            cnt <= (cnt == LOAD_LAST) ? '0 : cnt + 1'b1;
            if (x_in == 3'b100 || y_in == 3'b100) err_digit <= 1'b1;
          end
        end
        RUN:  cnt <= (cnt == RUN_LAST) ? '0 : cnt + 1'b1;
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Operand buffer.
  // NOTE: the buffer has no reset. It is always fully written in LOAD before
  // RUN reads it, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      dig_buf[idx] <= {(x_in == 3'b100) ? 3'd0 : x_in,
                       (y_in == 3'b100) ? 3'd0 : y_in};
    end
  end

endmodule
